// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the MIPS instruction-fetch and data ports.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IGRANT = 3'd1,
        DGRANT = 3'd2,
        IACK   = 3'd3,
        DACK   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              w_dreq;
    logic              w_fetch_due;
    logic              w_itake;
    logic              w_dtake;

    assign w_dreq  = dREN | dWEN;
    assign w_itake = (r_state == IGRANT) && iREN && ram_ready;
    assign w_dtake = (r_state == DGRANT) && w_dreq && ram_ready;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_starve;

    assign w_fetch_due = iREN && (r_starve == CNT_W'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch; saturates at STARVE_MAX.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= '0;
        end else if (r_state == IDLE && w_next == IGRANT) begin
            r_starve <= '0;
        end else if (r_state == IDLE && w_next == DGRANT && iREN &&
                     r_starve != CNT_W'(STARVE_MAX)) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end
`else
    assign w_fetch_due = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // RAM strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        w_next   = r_state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_fetch_due) begin
                    w_next = IGRANT;
                end else if (w_dreq) begin
                    w_next = DGRANT;
                end else if (iREN) begin
                    w_next = IGRANT;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    w_next = IDLE;
                end else if (ram_ready) begin
                    w_next = IACK;
                end
            end
            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (ram_ready) begin
                    w_next = DACK;
                end
            end
            IACK: begin
                iwait  = 1'b0;
                w_next = IDLE;
            end
            DACK: begin
                dwait  = 1'b0;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Stores leave dload untouched; only completed reads capture ramload.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            if (w_itake) begin
                r_iload <= ramload;
            end
            if (w_dtake && !dWEN) begin
                r_dload <= ramload;
            end
        end
    end

    assign iload = r_iload;
    assign dload = r_dload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard, corner sequences.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    // kind: 0 fetch, 1 load, 2 store with dREN also high, 3 store only
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
        int          k;
        logic [31:0] rdata;
        logic        exp_ren;
        logic        exp_wen;
        logic [31:0] exp_store;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic        ackq[$];
    logic        sb_en = 1'b1;
    logic [31:0] m_iload = '0;
    logic [31:0] m_dload = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Ack monitor: scoreboard compare in normal mode, ack-order logging in starvation mode.
    always @(negedge CLK) begin
        if (!iwait && !dwait) check("both_acks", 32'd1, 32'd0);
        if (!iwait) begin
            if (sb_en) begin
                if (iq.size() == 0) check("unexpected_iack", 32'd1, 32'd0);
                else check("sb_iload", iload, iq.pop_front());
            end else ackq.push_back(1'b1);
        end
        if (!dwait) begin
            if (sb_en) begin
                if (dq.size() == 0) check("unexpected_dack", 32'd1, 32'd0);
                else check("sb_dload", dload, dq.pop_front());
            end else ackq.push_back(1'b0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic is_fetch;
        is_fetch = (v.kind == 0);
        iREN   = is_fetch;
        iaddr  = is_fetch ? v.addr : ~v.addr;
        dREN   = (v.kind == 1) || (v.kind == 2);
        dWEN   = (v.kind >= 2);
        daddr  = is_fetch ? ~v.addr : v.addr;
        dstore = v.store;
        if (is_fetch) begin
            iq.push_back(v.rdata);
            m_iload = v.rdata;
        end else if (v.kind == 1) begin
            dq.push_back(v.rdata);
            m_dload = v.rdata;
        end else begin
            dq.push_back(m_dload);
        end
        ramload = ~v.rdata;
        for (int c = 1; c <= v.k + 1; c++) begin
            tick();
            if (c == 1) begin
                check("v_ramREN", {31'd0, ramREN}, {31'd0, v.exp_ren});
                check("v_ramWEN", {31'd0, ramWEN}, {31'd0, v.exp_wen});
                check("v_ramaddr", ramaddr, v.addr);
                check("v_ramstore", ramstore, v.exp_store);
            end
            if (c == v.k) begin
                check("v_wait_before_ack", {31'd0, is_fetch ? iwait : dwait}, 32'd1);
                ram_ready = 1'b1;
                ramload   = v.rdata;
            end
            if (c == v.k + 1) begin
                check("v_ack", {31'd0, is_fetch ? iwait : dwait}, 32'd0);
                check("v_iload", iload, m_iload);
                check("v_dload", dload, m_dload);
                ram_ready = 1'b0;
                ramload   = $urandom();
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            end
        end
        tick();
        check("v_wait_after_ack", {30'd0, iwait, dwait}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{0, 32'h40,  32'hA5A5A5A5, 1, 32'h8C220004, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1, 32'h100, 32'h5A5A5A5A, 3, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{2, 32'h200, 32'hDEADBEEF, 1, 32'hFFFF0000, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{0, 32'h44,  32'h0F0F0F0F, 2, 32'h00430820, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{3, 32'h204, 32'hCAFEF00D, 2, 32'h55AA55AA, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[5] = '{1, 32'h208, 32'h11111111, 1, 32'h0BADC0DE, 1'b1, 1'b0, 32'h0};

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        check("rst_waits", {30'd0, iwait, dwait}, 32'd3);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // simultaneous fetch and load: data first, fetch afterwards
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h100;
        dq.push_back(32'h11112222); m_dload = 32'h11112222;
        iq.push_back(32'h33334444); m_iload = 32'h33334444;
        tick();
        check("pri_ramaddr_c1", ramaddr, 32'h100);
        check("pri_ramREN_c1", {31'd0, ramREN}, 32'd1);
        tick();
        tick();
        ram_ready = 1'b1; ramload = 32'h11112222;
        tick();
        check("pri_dwait_c4", {31'd0, dwait}, 32'd0);
        check("pri_iwait_c4", {31'd0, iwait}, 32'd1);
        ram_ready = 1'b0; dREN = 1'b0;
        tick();
        check("pri_idle_c5", {31'd0, ramREN}, 32'd0);
        tick();
        check("pri_ramaddr_c6", ramaddr, 32'h48);
        check("pri_ramREN_c6", {31'd0, ramREN}, 32'd1);
        ram_ready = 1'b1; ramload = 32'h33334444;
        tick();
        check("pri_iwait_c7", {31'd0, iwait}, 32'd0);
        check("pri_iload_c7", iload, 32'h33334444);
        ram_ready = 1'b0; iREN = 1'b0;
        tick();

        // asynchronous reset in the middle of a data grant
        dREN = 1'b1; daddr = 32'h300;
        tick();
        check("mid_ramREN_before", {31'd0, ramREN}, 32'd1);
        check("mid_ramaddr_before", ramaddr, 32'h300);
        #2 nRST = 1'b0;
        #1;
        check("mid_ramREN", {31'd0, ramREN}, 32'd0);
        check("mid_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("mid_ramaddr", ramaddr, 32'd0);
        check("mid_ramstore", ramstore, 32'd0);
        check("mid_iload", iload, 32'd0);
        check("mid_dload", dload, 32'd0);
        check("mid_waits", {30'd0, iwait, dwait}, 32'd3);
        dREN = 1'b0; m_iload = '0; m_dload = '0;
        #1 nRST = 1'b1;
        tick();

        // fetch dropped before ram_ready, then stray ram_ready while idle
        iREN = 1'b1; iaddr = 32'h80;
        tick();
        check("abort_ramREN_c1", {31'd0, ramREN}, 32'd1);
        check("abort_ramaddr_c1", ramaddr, 32'h80);
        iREN = 1'b0;
        tick();
        check("abort_ramREN_c2", {31'd0, ramREN}, 32'd0);
        ram_ready = 1'b1; ramload = 32'h77777777;
        repeat (3) tick();
        check("abort_waits", {30'd0, iwait, dwait}, 32'd3);
        check("abort_iload", iload, m_iload);
        check("abort_dload", dload, m_dload);
        ram_ready = 1'b0;
        tick();

        // continuous fetch and load requests
        sb_en = 1'b0;
        ackq.delete();
        iREN = 1'b1; iaddr = 32'h90; dREN = 1'b1; daddr = 32'h400;
        ram_ready = 1'b1; ramload = 32'h0;
        n = 0;
        while (ackq.size() < 10 && n < 60) begin
            tick();
            n++;
        end
        iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
        check("starve_ack_count", ackq.size(), 32'd10);
        for (int i = 0; i < 10 && i < ackq.size(); i++) begin
`ifdef MEM_ARB_FAIR_EN
            check($sformatf("starve_ack_%0d", i), {31'd0, ackq[i]}, {31'd0, (i % 5) == 4});
`else
            check($sformatf("starve_ack_%0d", i), {31'd0, ackq[i]}, 32'd0);
`endif
        end
        repeat (3) tick();
        sb_en = 1'b1;

        check("sb_iq_empty", iq.size(), 32'd0);
        check("sb_dq_empty", dq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
